// File: rtl/seq_detect_param_if.sv
// Symbol stream, pattern load and status bundle for seq_detect_param.
// master drives symbols/controls, slave is the detector.
interface seq_detect_param_if #(
  parameter int unsigned SYM_W = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) ();
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);

  logic                     sym_valid;
  logic [SYM_W-1:0]         sym;
  logic                     pat_load;
  logic [SYM_W*DEPTH-1:0]   pat_in;
  logic                     overlap;
  logic                     clr_cnt;
  logic                     match;
  logic [CNT_W-1:0]         match_cnt;
  logic [FILL_W-1:0]        fill;

  modport master (
    output sym_valid, sym, pat_load, pat_in, overlap, clr_cnt,
    input  match, match_cnt, fill
  );

  modport slave (
    input  sym_valid, sym, pat_load, pat_in, overlap, clr_cnt,
    output match, match_cnt, fill
  );
endinterface

// File: rtl/seq_detect_param.sv
// Streaming detector: compares the last DEPTH accepted symbols against a loadable
// pattern, pulses match for one cycle per hit and keeps a saturating hit count.
module seq_detect_param #(
  parameter int unsigned          SYM_W   = 2,
  parameter int unsigned          DEPTH   = 4,
  parameter int unsigned          CNT_W   = 8,
  parameter logic [SYM_W*DEPTH-1:0] PAT_RST = '0
) (
  input  logic              clk,
  input  logic              reset,
  seq_detect_param_if.slave bus
);
  localparam int unsigned HIST_W = SYM_W * DEPTH;
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

  logic [HIST_W-1:0] pat_q, pat_d;
  logic [HIST_W-1:0] hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              match_q, match_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [HIST_W-1:0] hist_shift;
  logic [FILL_W-1:0] fill_inc;
  logic              hit;

  // Truncating the concatenation drops the oldest symbol; also covers DEPTH=1.
  assign hist_shift = HIST_W'({hist_q, bus.sym});
  assign fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
  assign hit        = bus.sym_valid && !bus.pat_load &&
                      (fill_inc == FILL_FULL) && (hist_shift == pat_q);

  always_comb begin
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    cnt_d   = cnt_q;

    if (bus.pat_load) begin
      pat_d  = bus.pat_in;
      fill_d = '0;
    end else if (bus.sym_valid) begin
      hist_d = hist_shift;
      fill_d = fill_inc;
      if (hit) begin
        match_d = 1'b1;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // Non-overlapping: stale history stays in hist but is ignored until refilled.
        if (!bus.overlap) begin
          fill_d = '0;
        end
      end
    end

    if (bus.clr_cnt) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q   <= PAT_RST;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.match     = match_q;
  assign bus.match_cnt = cnt_q;
  assign bus.fill      = fill_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: two instances (8-bit and 2-bit counters) share one
// stimulus stream and are checked against a queue-based window model.
module tb_seq_detect_param;
  localparam int unsigned SYM_W = 2;
  localparam int unsigned DEPTH = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       d_valid = 1'b0;
  logic [1:0] d_sym = 2'b00;
  logic       d_load = 1'b0;
  logic [5:0] d_pat = 6'b0;
  logic       d_ovl = 1'b1;
  logic       d_clr = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seq_detect_param_if #(.SYM_W(SYM_W), .DEPTH(DEPTH), .CNT_W(8)) if_a ();
  seq_detect_param_if #(.SYM_W(SYM_W), .DEPTH(DEPTH), .CNT_W(2)) if_b ();

  assign if_a.sym_valid = d_valid;
  assign if_a.sym       = d_sym;
  assign if_a.pat_load  = d_load;
  assign if_a.pat_in    = d_pat;
  assign if_a.overlap   = d_ovl;
  assign if_a.clr_cnt   = d_clr;
  assign if_b.sym_valid = d_valid;
  assign if_b.sym       = d_sym;
  assign if_b.pat_load  = d_load;
  assign if_b.pat_in    = d_pat;
  assign if_b.overlap   = d_ovl;
  assign if_b.clr_cnt   = d_clr;

  seq_detect_param #(.SYM_W(SYM_W), .DEPTH(DEPTH), .CNT_W(8), .PAT_RST(6'b0)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a)
  );

  seq_detect_param #(.SYM_W(SYM_W), .DEPTH(DEPTH), .CNT_W(2), .PAT_RST(6'b0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b)
  );

  // Reference model: the accepted symbols since the last restart form the window;
  // a hit is simply "window full and equal to the pattern".
  logic [1:0] win[$];
  logic [1:0] mpat[DEPTH];
  logic       m_match;
  int         m_hits;

  function automatic logic [15:0] expv();
    int f8, f2;
    f8 = (m_hits > 255) ? 255 : m_hits;
    f2 = (m_hits > 3) ? 3 : m_hits;
    return {m_match, 2'(win.size()), 8'(f8), m_match, 2'(win.size()), 2'(f2)};
  endfunction

  function automatic logic [15:0] obs();
    return {if_a.match, if_a.fill, if_a.match_cnt, if_b.match, if_b.fill, if_b.match_cnt};
  endfunction

  task automatic model_reset();
    win.delete();
    for (int i = 0; i < DEPTH; i++) mpat[i] = 2'b00;
    m_match = 1'b0;
    m_hits  = 0;
  endtask

  task automatic model_step();
    logic eq;
    m_match = 1'b0;
    if (d_load) begin
      for (int i = 0; i < DEPTH; i++) mpat[i] = d_pat[SYM_W*(DEPTH-1-i) +: SYM_W];
      win.delete();
    end else if (d_valid) begin
      win.push_back(d_sym);
      if (win.size() > DEPTH) void'(win.pop_front());
      if (win.size() == DEPTH) begin
        eq = 1'b1;
        for (int i = 0; i < DEPTH; i++) if (win[i] != mpat[i]) eq = 1'b0;
        if (eq) begin
          m_match = 1'b1;
          m_hits++;
          if (!d_ovl) win.delete();
        end
      end
    end
    if (d_clr) m_hits = 0;
  endtask

  // One clock: model consumes the driven inputs, DUT samples them, then pulses drop.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    d_valid = 1'b0;
    d_load  = 1'b0;
    d_clr   = 1'b0;
  endtask

  task automatic sym_cyc(input logic [1:0] s);
    d_valid = 1'b1;
    d_sym   = s;
    step();
  endtask

  task automatic load_cyc(input logic [5:0] p);
    d_load = 1'b1;
    d_pat  = p;
    step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (obs() !== 16'h0) begin
      bad++;
      $display("FAIL reset_state: got %h want %h", obs(), 16'h0);
    end
  endtask

  task automatic test_basic();
    logic [1:0] s[3] = '{2'b10, 2'b11, 2'b01};
    do_reset();
    d_ovl = 1'b1;
    load_cyc(6'b101101);
    for (int i = 0; i < 3; i++) begin
      sym_cyc(s[i]);
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL basic_model[%0d]: got %h want %h", i, obs(), expv());
      end
    end
    total++;
    if (if_a.match !== 1'b1 || if_a.match_cnt !== 8'd1 || if_a.fill !== 2'd3) begin
      bad++;
      $display("FAIL basic_hit: match=%b cnt=%0d fill=%0d want 1/1/3",
               if_a.match, if_a.match_cnt, if_a.fill);
    end
    step();
    total++;
    if (if_a.match !== 1'b0) begin
      bad++;
      $display("FAIL basic_pulse_width: match=%b want 0", if_a.match);
    end
  endtask

  task automatic test_overlap();
    logic [5:0] pulses;
    logic       fill_ok;
    for (int mode = 1; mode >= 0; mode--) begin
      do_reset();
      d_ovl = mode[0];
      load_cyc(6'b010101);
      pulses  = '0;
      fill_ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
        sym_cyc(2'b01);
        pulses[i] = if_a.match;
        if (!d_ovl && if_a.match && if_a.fill !== 2'd0) fill_ok = 1'b0;
        total++;
        if (obs() !== expv()) begin
          bad++;
          $display("FAIL overlap_model[m%0d,%0d]: got %h want %h", mode, i, obs(), expv());
        end
      end
      total++;
      if (pulses !== (mode ? 6'b111100 : 6'b100100) ||
          if_a.match_cnt !== (mode ? 8'd4 : 8'd2) || !fill_ok) begin
        bad++;
        $display("FAIL overlap_mode%0d: pulses=%b cnt=%0d fill_ok=%b", mode, pulses,
                 if_a.match_cnt, fill_ok);
      end
    end
  endtask

  task automatic test_gaps();
    logic [1:0] s[6] = '{2'b10, 2'b11, 2'b01, 2'b10, 2'b11, 2'b00};
    int pulses = 0;
    do_reset();
    d_ovl = 1'b0;
    load_cyc(6'b101101);
    for (int i = 0; i < 6; i++) begin
      sym_cyc(s[i]);
      pulses += int'(if_a.match);
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL gaps_model[%0d]: got %h want %h", i, obs(), expv());
      end
      if (i < 2) begin
        step();
        step();
      end
    end
    total++;
    if (pulses != 1 || if_a.fill !== 2'd3 || if_a.match !== 1'b0) begin
      bad++;
      $display("FAIL gaps_nearmiss: pulses=%0d fill=%0d want 1 pulse fill 3", pulses, if_a.fill);
    end
  endtask

  task automatic test_sat_clear();
    do_reset();
    d_ovl = 1'b0;
    load_cyc(6'b101101);
    for (int r = 0; r < 7; r++) begin
      sym_cyc(2'b10);
      sym_cyc(2'b11);
      if (r == 5) d_clr = 1'b1;
      sym_cyc(2'b01);
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL sat_model[%0d]: got %h want %h", r, obs(), expv());
      end
      if (r == 4) begin
        total++;
        if (if_b.match_cnt !== 2'd3 || if_a.match_cnt !== 8'd5) begin
          bad++;
          $display("FAIL sat_hold: cnt2=%0d cnt8=%0d want 3/5", if_b.match_cnt, if_a.match_cnt);
        end
      end
      if (r == 5) begin
        total++;
        if (if_b.match !== 1'b1 || if_b.match_cnt !== 2'd0 || if_a.match_cnt !== 8'd0) begin
          bad++;
          $display("FAIL clr_priority: match=%b cnt2=%0d cnt8=%0d want 1/0/0",
                   if_b.match, if_b.match_cnt, if_a.match_cnt);
        end
      end
    end
    total++;
    if (if_b.match_cnt !== 2'd1) begin
      bad++;
      $display("FAIL clr_then_hit: cnt2=%0d want 1", if_b.match_cnt);
    end
  endtask

  task automatic test_load_midstream();
    int pulses = 0;
    do_reset();
    d_ovl = 1'b1;
    load_cyc(6'b101101);
    sym_cyc(2'b10);
    sym_cyc(2'b11);
    d_valid = 1'b1;
    d_sym   = 2'b01;
    load_cyc(6'b000000);
    total++;
    if (if_a.fill !== 2'd0 || if_a.match !== 1'b0) begin
      bad++;
      $display("FAIL load_mid: fill=%0d match=%b want 0/0", if_a.fill, if_a.match);
    end
    for (int i = 0; i < 3; i++) begin
      sym_cyc(2'b00);
      if (i < 2) pulses += int'(if_a.match);
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL load_model[%0d]: got %h want %h", i, obs(), expv());
      end
    end
    total++;
    if (pulses != 0 || if_a.match !== 1'b1) begin
      bad++;
      $display("FAIL load_newpat: early=%0d match=%b want 0/1", pulses, if_a.match);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    d_ovl = 1'b1;
    load_cyc(6'b101101);
    sym_cyc(2'b10);
    sym_cyc(2'b11);
    sym_cyc(2'b01);
    sym_cyc(2'b10);
    sym_cyc(2'b11);
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    total++;
    if (obs() !== 16'h0) begin
      bad++;
      $display("FAIL async_reset: got %h want %h", obs(), 16'h0);
    end
    @(posedge clk);
    #3;
    reset = 1'b1;
    #2;
    sym_cyc(2'b01);
    total++;
    if (if_a.match !== 1'b0 || if_a.fill !== 2'd1) begin
      bad++;
      $display("FAIL post_reset_first: match=%b fill=%0d want 0/1", if_a.match, if_a.fill);
    end
    // Pattern back at PAT_RST (all zero): window 01,00,00 misses, next 00 hits.
    for (int i = 0; i < 3; i++) begin
      sym_cyc(2'b00);
      total++;
      if (obs() !== expv() || if_a.match !== (i == 2)) begin
        bad++;
        $display("FAIL post_reset_pat[%0d]: got %h want %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_random();
    int hits = 0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      d_valid = ($urandom_range(0, 3) != 0);
      d_sym   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) d_ovl = ~d_ovl;
      if ($urandom_range(0, 59) == 0) begin
        d_load = 1'b1;
        d_pat  = 6'($urandom_range(0, 63));
      end
      d_clr = ($urandom_range(0, 79) == 0);
      step();
      hits += int'(m_match);
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL random[%0d]: got %h want %h", n, obs(), expv());
      end
    end
    total++;
    if (hits == 0) begin
      bad++;
      $display("FAIL random_coverage: hits=%0d want >0", hits);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_overlap();
    test_gaps();
    test_sat_clear();
    test_load_midstream();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: sim time exceeded, want finish");
    $fatal(1);
  end
endmodule
